// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and FSM encoding for the
// chunk-serial multiword adder.
package multiword_add_seq_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multiword_add_seq_rca.sv
// 16-bit ripple-carry adder; the only adder
// in the multiword datapath.
module rca
  import multiword_add_seq_pkg::*;
(
  input  logic               cin,
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK_W];

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two W-bit operands one 16-bit chunk per
// cycle through a single shared ripple adder.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter  int NUM_CHUNKS = 4,
  localparam int W          = CHUNK_W * NUM_CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_CHUNKS - 1);

  state_e           state_q;
  state_e           state_d;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [CHUNK_W-1:0] rca_a;
  logic [CHUNK_W-1:0] rca_b;
  logic [CHUNK_W-1:0] rca_sum;
  logic               rca_cout;
  logic               accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)            state_d = RUN;
      RUN:  if (idx_q == LAST_IDX) state_d = DONE;
      DONE: if (out_ready)         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign rca_a = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
  assign rca_b = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];

  rca u_rca (
    .cin  (carry_q),
    .a    (rca_a),
    .b    (rca_b),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // Operands are only sampled on accept, so
  // input wiggles outside IDLE never reach the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[int'(idx_q)*CHUNK_W +: CHUNK_W]
                  <= rca_sum;
          carry_q <= rca_cout;
          idx_q   <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for the
// chunk-serial multiword adder.
module tb_multiword_add_seq;

  localparam int NC = 4;
  localparam int W  = 16 * NC;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.NUM_CHUNKS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic logic [W:0] ref_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = rnd_word();
    b        = rnd_word();
    cin      = $urandom_range(0, 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1",
               in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0",
               out_valid);
    end
    total++;
    if ({cout, sum} !== '0) begin
      bad++;
      $display("FAIL reset_sum got=%b_%h want=0",
               cout, sum);
    end
  endtask

  task automatic test_known(
    input string        name,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c,
    input logic [W:0]   want
  );
    int cyc;
    start_op(x, y, c);
    wait_done(cyc);
    total++;
    if (cyc !== NC) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d",
               name, cyc, NC);
    end
    total++;
    if ({cout, sum} !== want) begin
      bad++;
      $display("FAIL %s_sum got=%b_%h want=%b_%h",
               name, cout, sum, want[W], want[W-1:0]);
    end
    release_out();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_release rdy=%b vld=%b want=1,0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_hold();
    logic [W:0] want;
    int         cyc;
    int         rdy_bad;
    int         hold_bad;
    want    = ref_add(64'h1234_5678_9ABC_DEF0,
                      64'hFEDC_BA98_7654_3210, 1'b1);
    start_op(64'h1234_5678_9ABC_DEF0,
             64'hFEDC_BA98_7654_3210, 1'b1);
    cyc     = 0;
    rdy_bad = 0;
    while (!out_valid && cyc < 50) begin
      if (in_ready !== 1'b0) rdy_bad++;
      a        = rnd_word();
      b        = rnd_word();
      cin      = $urandom_range(0, 1);
      in_valid = $urandom_range(0, 1);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (cyc !== NC) begin
      bad++;
      $display("FAIL hold_latency got=%0d want=%0d",
               cyc, NC);
    end
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
        rdy_bad++;
      if ({cout, sum} !== want) hold_bad++;
      a   = rnd_word();
      b   = rnd_word();
      tick();
    end
    total++;
    if (rdy_bad !== 0) begin
      bad++;
      $display("FAIL hold_handshake got=%0d want=0",
               rdy_bad);
    end
    total++;
    if (hold_bad !== 0 || {cout, sum} !== want) begin
      bad++;
      $display("FAIL hold_sum got=%b_%h want=%b_%h",
               cout, sum, want[W], want[W-1:0]);
    end
    release_out();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release rdy=%b vld=%b want=1,0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    start_op('1, '1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {cout, sum} !== '0) begin
      bad++;
      $display("FAIL rst_run got=%b%b_%b_%h want=10_0_0",
               in_ready, out_valid, cout, sum);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_ghost got=%0d want=0", seen);
    end
    test_known("after_rst", 64'h1, 64'h1, 1'b0,
               65'h2);
    start_op('1, 64'h5, 1'b0);
    wait_done(seen);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {cout, sum} !== '0) begin
      bad++;
      $display("FAIL rst_done got=%b%b_%b_%h want=10_0_0",
               in_ready, out_valid, cout, sum);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    logic [W:0]   want;
    int           cyc;
    int           wait_cyc;
    for (int n = 0; n < 1000; n++) begin
      x    = rnd_word();
      y    = rnd_word();
      c    = $urandom_range(0, 1);
      want = ref_add(x, y, c);
      repeat ($urandom_range(0, 2)) tick();
      start_op(x, y, c);
      wait_done(cyc);
      total++;
      if (cyc !== NC) begin
        bad++;
        $display("FAIL rand_latency op=%0d got=%0d",
                 n, cyc);
      end
      wait_cyc = 0;
      out_ready = $urandom_range(0, 1);
      while (!out_ready && wait_cyc < 20) begin
        tick();
        wait_cyc++;
        out_ready = $urandom_range(0, 1);
      end
      out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b1 || {cout, sum} !== want) begin
        bad++;
        $display("FAIL rand_sum op=%0d got=%b_%h want=%b_%h",
                 n, cout, sum, want[W], want[W-1:0]);
      end
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    test_reset();
    test_known("chunk_carry", 64'h0000_0000_0000_FFFF,
               64'h1, 1'b0, 65'h0_0000_0000_0001_0000);
    test_known("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 1'b1, 65'h1_0000_0000_0000_0000);
    test_known("latency", 64'h0000_EEEE_00FF_EEEE,
               64'h0000_1001_2200_1001, 1'b0,
               65'h0_0000_FEEF_22FF_FEEF);
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
